// File: rtl/baud_frac_clkgen.sv
// Multi-channel fractional baud clock generator: each channel toggles clk_out whenever
// the integer part of its free-running phase counter meets a fixed-point target.
module baud_frac_clkgen #(
  parameter int NUM_CH = 2,
  parameter int WIDTH = 32,
  parameter int FRAC_BITS = 7,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 32'h00000A00,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [WIDTH-1:0] ONE_P = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;

  logic [NUM_CH-1:0][WIDTH-1:0] acc_r;
  logic [NUM_CH-1:0][WIDTH-1:0] target_r;
  logic [NUM_CH-1:0][WIDTH-1:0] half_r;
  logic [NUM_CH-1:0][WIDTH-1:0] shadow_r;
  logic [NUM_CH-1:0][WIDTH-1:0] div_s;
  logic [NUM_CH-1:0]            evt_s;
  logic [NUM_CH-1:0]            wr_s;

  // A divisor below 1.0 would stall the generator, so it is forced up to exactly 1.0.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1:FRAC_BITS] == {(WIDTH-FRAC_BITS){1'b0}}) begin
      clamp_div = ONE_P;
    end else begin
      clamp_div = v;
    end
  endfunction

  // Per-channel event detection, next divisor selection and write decode.
  always_comb begin
    evt_s = {NUM_CH{1'b0}};
    wr_s  = {NUM_CH{1'b0}};
    div_s = {(NUM_CH*WIDTH){1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      evt_s[c] = en[c] & (acc_r[c][WIDTH-1:FRAC_BITS] == target_r[c][WIDTH-1:FRAC_BITS]);
      div_s[c] = pend[c] ? shadow_r[c] : half_r[c];
      wr_s[c]  = cfg_we & (int'(cfg_ch) == c);
    end
  end

  // Channel state registers; a write in the same cycle always lands after sync/event updates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r    <= {(NUM_CH*WIDTH){1'b0}};
      target_r <= {NUM_CH{DEFAULT_DIV}};
      half_r   <= {NUM_CH{DEFAULT_DIV}};
      shadow_r <= {NUM_CH{DEFAULT_DIV}};
      pend     <= {NUM_CH{1'b0}};
      clk_out  <= {NUM_CH{1'b0}};
      tick     <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sync) begin
          acc_r[c]    <= {WIDTH{1'b0}};
          clk_out[c]  <= 1'b0;
          tick[c]     <= 1'b0;
          target_r[c] <= div_s[c];
          half_r[c]   <= div_s[c];
          pend[c]     <= 1'b0;
        end else begin
          if (en[c]) begin
            acc_r[c] <= acc_r[c] + ONE_P;
          end
          tick[c] <= evt_s[c];
          if (evt_s[c]) begin
            clk_out[c]  <= ~clk_out[c];
            target_r[c] <= target_r[c] + div_s[c];
            half_r[c]   <= div_s[c];
            pend[c]     <= 1'b0;
          end
        end
        if (wr_s[c]) begin
          shadow_r[c] <= clamp_div(cfg_div);
          pend[c]     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_frac_clkgen.sv
// Bench for baud_frac_clkgen: directed toggle-time tables, reload/enable/reset sequences,
// and randomized traffic scored against an unbounded-phase reference model.
module tb_baud_frac_clkgen;

  localparam int NUM_CH = 3;
  localparam int WIDTH = 12;
  localparam int FRAC_BITS = 7;
  localparam int CH_W = 2;
  localparam logic [WIDTH-1:0] DEF = 12'hA00;

  logic              clock;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [WIDTH-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  baud_frac_clkgen #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .DEFAULT_DIV(DEF)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: phase counted in enabled cycles with no wrap; the k-th toggle
  // happens when that count reaches floor(sum of the half-periods applied so far).
  longint m_cnt [NUM_CH];
  longint m_tgt [NUM_CH];
  int     m_half [NUM_CH];
  int     m_shadow [NUM_CH];
  bit     m_pend [NUM_CH];
  bit     m_clk [NUM_CH];
  bit     m_tick [NUM_CH];

  typedef struct {
    logic [WIDTH-1:0] div;
    int               e [5];
  } vec_t;
  vec_t tbl [5];
  int got [$];
  int got1 [$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_tgt[c] = longint'(DEF); m_half[c] = int'(DEF); m_shadow[c] = int'(DEF);
      m_pend[c] = 1'b0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    int d;
    bit ev;
    for (int c = 0; c < NUM_CH; c++) begin
      d = m_pend[c] ? m_shadow[c] : m_half[c];
      if (sync) begin
        m_cnt[c] = 0; m_tgt[c] = d; m_half[c] = d;
        m_pend[c] = 1'b0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
      end else begin
        ev = en[c] && (m_cnt[c] == (m_tgt[c] >>> FRAC_BITS));
        m_tick[c] = ev;
        if (en[c]) m_cnt[c]++;
        if (ev) begin
          m_clk[c] = ~m_clk[c]; m_tgt[c] += d; m_half[c] = d; m_pend[c] = 1'b0;
        end
      end
      if (cfg_we && (int'(cfg_ch) == c)) begin
        m_shadow[c] = (int'(cfg_div) < (1 << FRAC_BITS)) ? (1 << FRAC_BITS) : int'(cfg_div);
        m_pend[c] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    logic [NUM_CH-1:0] ec, et, ep;
    @(posedge clock);
    model_step();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[c] = m_clk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    check("model_clk_out", longint'(clk_out), longint'(ec));
    check("model_tick", longint'(tick), longint'(et));
    check("model_pend", longint'(pend), longint'(ep));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_clk_out", longint'(clk_out), 0);
    check("reset_tick", longint'(tick), 0);
    check("reset_pend", longint'(pend), 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_edges(input int n, input int ch);
    got.delete();
    for (int k = 1; k <= n; k++) begin
      cycle();
      if (tick[ch]) got.push_back(k);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0].div = 12'hA00; tbl[0].e = '{21, 41, 61, 81, 101};
    tbl[1].div = 12'h140; tbl[1].e = '{3, 6, 8, 11, 13};
    tbl[2].div = 12'h040; tbl[2].e = '{2, 3, 4, 5, 6};
    tbl[3].div = 12'h500; tbl[3].e = '{11, 21, 31, 41, 51};
    tbl[4].div = 12'h0C0; tbl[4].e = '{2, 4, 5, 7, 8};

    en = 3'b000; sync = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 12'h000;
    do_reset();
    en = 3'b111;

    // Toggle schedules after writing a divisor and restarting the phase.
    for (int i = 0; i < 5; i++) begin
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = tbl[i].div;
      cycle();
      cfg_we = 1'b0; sync = 1'b1;
      cycle();
      sync = 1'b0;
      run_edges(tbl[i].e[4], 0);
      check("tbl_tick_count", got.size(), 5);
      for (int j = 0; j < 5; j++) check("tbl_toggle_edge", got[j], tbl[i].e[j]);
      check("tbl_clk_final", clk_out[0], 1);
    end

    // Reload mid half-period: current 20 kept, then 10-cycle half-periods.
    do_reset();
    for (int k = 1; k <= 5; k++) cycle();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 12'h500;
    cycle();
    cfg_we = 1'b0;
    check("reload_pend_set", pend[0], 1);
    got.delete();
    for (int k = 7; k <= 55; k++) begin
      cycle();
      if (tick[0]) got.push_back(k);
      if (k == 20) check("reload_pend_before", pend[0], 1);
      if (k == 21) check("reload_pend_clear", pend[0], 0);
    end
    check("reload_tick_count", got.size(), 4);
    check("reload_edge0", got[0], 21);
    check("reload_edge1", got[1], 31);
    check("reload_edge2", got[2], 41);
    check("reload_edge3", got[3], 51);

    // Enable gap of 5 cycles on ch0 while the 5-bit integer phase wraps several times.
    do_reset();
    got.delete(); got1.delete();
    for (int k = 1; k <= 90; k++) begin
      en = (k >= 25 && k <= 29) ? 3'b110 : 3'b111;
      cycle();
      if (tick[0]) got.push_back(k);
      if (tick[1]) got1.push_back(k);
    end
    en = 3'b111;
    check("wrap_ch0_count", got.size(), 4);
    check("wrap_ch0_e0", got[0], 21);
    check("wrap_ch0_e1", got[1], 46);
    check("wrap_ch0_e2", got[2], 66);
    check("wrap_ch0_e3", got[3], 86);
    check("wrap_ch1_count", got1.size(), 4);
    check("wrap_ch1_e3", got1[3], 81);

    // Write to a nonexistent channel changes nothing.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 12'h040;
    cycle();
    cfg_we = 1'b0;
    check("illegal_pend", longint'(pend), 0);
    for (int k = 0; k < 10; k++) cycle();

    // Reset while a write is pending, then default schedule resumes.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 12'h140;
    cycle();
    cfg_we = 1'b0; sync = 1'b1;
    cycle();
    sync = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    cfg_we = 1'b1; cfg_div = 12'h500;
    cycle();
    cfg_we = 1'b0;
    check("midrst_pend_before", pend[0], 1);
    check("midrst_clk_before", clk_out[0], 1);
    #2;
    do_reset();
    run_edges(21, 0);
    check("midrst_tick_count", got.size(), 1);
    check("midrst_first_edge", got[0], 21);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111;
      sync = ($urandom_range(0, 199) == 0);
      cfg_we = ($urandom_range(0, 14) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_div = 12'($urandom_range(0, 12'h7FF));
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
